fetch_stage: RTL

Front-end stage of the five-stage 16-bit pipeline.
- Owns the PC and drives the instruction-memory address.
- Fills the pipeline-1 register (PC, IR, valid) that the decode stage reads.
- Expands multi-register LM/SM instructions into a sequence of single LW/SW micro-ops, so decode and later stages only ever see single-register memory instructions.
- Handles downstream stall and branch/jump redirect (flush).

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_lmsm_seq.sv | 25 ++
 rtl/fetch_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: opcodes, field positions, defaults and helpers shared by the fetch stage.
package fetch_stage_pkg;
  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;
  localparam logic [15:0] BUBBLE_IR_DEF = 16'hFFFF;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam int RA_MSB = 11;
  localparam int RA_LSB = 9;
  localparam int RB_MSB = 8;
  localparam int RB_LSB = 6;
  localparam int BM_MSB = 7;
  localparam int BM_LSB = 0;
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
    logic        valid;
  } pipe1_t;
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    popcount8 = 4'd0;
    for (int i = 0; i < 8; i++) popcount8 = popcount8 + {3'd0, v[i]};
  endfunction
endpackage

// File: rtl/fetch_stage_lmsm_seq.sv
// lmsm_seq: picks the next LM/SM register (base register last for LM) and its memory offset.
module lmsm_seq
  import fetch_stage_pkg::*;
(
  input  logic [7:0] rem,
  input  logic [7:0] orig,
  input  logic [2:0] ra,
  input  logic       is_lm,
  output logic [2:0] idx,
  output logic [2:0] k,
  output logic       last
);
  logic [7:0] no_base, pick, below;
  logic [3:0] cnt;
  always_comb begin
    no_base = rem & ~(8'b1 << ra);
    pick = (is_lm && no_base != 8'd0) ? no_base : rem;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (pick[i]) idx = 3'(i);
    below = orig & ((8'b1 << idx) - 8'd1);
    cnt = popcount8(below);
    k = cnt[2:0];
    last = (rem & (rem - 8'd1)) == 8'd0;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and pipe1 filler; expands LM/SM into single LW/SW micro-ops.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [15:0] BUBBLE_IR = BUBBLE_IR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pipe1_pc,
  output logic [15:0] pipe1_ir,
  output logic        pipe1_valid,
  output logic        lmsm_busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEQ  = 1'b1;
  logic [0:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  rem_q, rem_d, orig_q, orig_d;
  logic [2:0]  ra_q, ra_d;
  logic        lm_q, lm_d;
  pipe1_t      pipe1_q, pipe1_d;
  logic        in_seq, is_lmsm, seq_lm, last;
  logic [7:0]  seq_rem, seq_orig, rem_left;
  logic [2:0]  seq_ra, idx, k;
  logic [15:0] uop;
  lmsm_seq u_seq (
    .rem  (seq_rem),
    .orig (seq_orig),
    .ra   (seq_ra),
    .is_lm(seq_lm),
    .idx  (idx),
    .k    (k),
    .last (last)
  );
  // In SEQ the pick logic runs on the latched instruction, otherwise on the word being fetched.
  always_comb begin
    in_seq = state_q == SEQ;
    is_lmsm = imem_data[15:13] == OP_LM[3:1];
    seq_rem = in_seq ? rem_q : imem_data[BM_MSB:BM_LSB];
    seq_orig = in_seq ? orig_q : imem_data[BM_MSB:BM_LSB];
    seq_ra = in_seq ? ra_q : imem_data[RA_MSB:RA_LSB];
    seq_lm = in_seq ? lm_q : imem_data[12] == OP_LM[0];
    uop = {seq_lm ? OP_LW : OP_SW, idx, seq_ra, 3'b000, k};
    rem_left = seq_rem & ~(8'b1 << idx);
    state_d = state_q;
    pc_d = pc_q;
    rem_d = rem_q;
    orig_d = orig_q;
    ra_d = ra_q;
    lm_d = lm_q;
    pipe1_d = pipe1_q;
    if (redirect) begin
      pc_d = redirect_pc;
      pipe1_d = '{pc: pipe1_q.pc, ir: BUBBLE_IR, valid: 1'b0};
      state_d = IDLE;
      rem_d = 8'd0;
    end else if (!stall) begin
      if (in_seq) begin
        pipe1_d = '{pc: pc_q, ir: uop, valid: 1'b1};
        rem_d = rem_left;
        if (last) begin
          pc_d = pc_q + 16'd1;
          state_d = IDLE;
        end
      end else if (!is_lmsm) begin
        pipe1_d = '{pc: pc_q, ir: imem_data, valid: 1'b1};
        pc_d = pc_q + 16'd1;
      end else if (imem_data[BM_MSB:BM_LSB] == 8'd0) begin
        pipe1_d = '{pc: pipe1_q.pc, ir: BUBBLE_IR, valid: 1'b0};
        pc_d = pc_q + 16'd1;
      end else begin
        pipe1_d = '{pc: pc_q, ir: uop, valid: 1'b1};
        if (last) pc_d = pc_q + 16'd1;
        else begin
          state_d = SEQ;
          rem_d = rem_left;
          orig_d = seq_orig;
          ra_d = seq_ra;
          lm_d = seq_lm;
        end
      end
    end
  end
  // pc stays on the parent LM/SM while in SEQ, so it doubles as the latched parent PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      rem_q <= 8'd0;
      orig_q <= 8'd0;
      ra_q <= 3'd0;
      lm_q <= 1'b0;
      pipe1_q <= '{pc: 16'd0, ir: BUBBLE_IR, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      rem_q <= rem_d;
      orig_q <= orig_d;
      ra_q <= ra_d;
      lm_q <= lm_d;
      pipe1_q <= pipe1_d;
    end
  end
  assign imem_addr = pc_q;
  assign pipe1_pc = pipe1_q.pc;
  assign pipe1_ir = pipe1_q.ir;
  assign pipe1_valid = pipe1_q.valid;
  assign lmsm_busy = state_q == SEQ;
endmodule
